tmr_ctrl_regs: RTL
==================

# tmr_ctrl_regs

Multi-channel control/status register bank for the APB timer, generalising the single-channel timer control register to N_CH channels. Each channel gets a control register (enable, direction, clock select, interrupt enable, self-clearing load strobe), a sticky status register with write-1-to-clear, and a shadowed clock-select field that updates only on a counter boundary while the channel runs. It sits between the APB slave decode and the per-channel counter cores, and drives the combined timer interrupt.

## Interface
- N_CH, 4, number of timer channels (1..16)
- CS_W, 2, clock-select field width (1..4)
- AW, $clog2(N_CH) (min 1), derived channel address width; not overridden

- i_clk_sys  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_wren  in  1  register write strobe, one transfer per cycle
- i_rden  in  1  register read strobe
- i_addr  in  AW  channel select
- i_sel  in  1  0 = control register, 1 = status register
- i_wdata  in  8  write data
- o_rdata  out  8  registered read data
- i_ovf  in  N_CH  per-channel overflow event, one-cycle pulse
- i_udf  in  N_CH  per-channel underflow event, one-cycle pulse
- i_upd  in  N_CH  per-channel counter boundary (reload) event
- o_en  out  N_CH  channel enable
- o_dir  out  N_CH  0 = count up, 1 = count down
- o_cs  out  N_CH*CS_W  active clock select, channel k at [k*CS_W +: CS_W]
- o_load  out  N_CH  one-cycle load strobe to counter
- o_irq  out  1  combined interrupt

## Operation
- Control layout: bit0 EN, bit1 DIR, bits[2 +: CS_W] CS, bit6 IE, bit7 LOAD; unimplemented bits read 0.
- Status layout: bit0 OVF (sticky, W1C), bit1 UDF (sticky, W1C), bit2 CSP (clock-select pending, read-only); others read 0.
- i_addr >= N_CH: writes ignored, reads return 0x00.
- EN, DIR, IE: written directly on control write.
- CS shadowing:
  - If EN is 1 before the write and the written EN is 1: CS goes to a shadow register and CSP is set.
  - Otherwise: CS is written to the active register and CSP is cleared.
  - On i_upd[k] with CSP set: active CS takes the shadow value and CSP clears.
  - Same-cycle i_upd and shadowed write: the old shadow applies and the new value becomes pending (CSP stays 1).
  - A second shadowed write before i_upd overwrites the shadow.
  - Read of control returns the active CS, not the shadow.
- LOAD:
  - Writing 1 to bit7 pulses o_load[k] high for exactly one cycle, independent of EN.
  - LOAD is never stored and always reads 0.
- Status flags:
  - i_ovf[k] sets OVF and i_udf[k] sets UDF, regardless of IE.
  - Writing 1 to the corresponding status bit clears the flag; writing 0 has no effect.
  - Same-cycle set and clear: set wins.
  - Writes to status never affect control.
- o_irq = OR over k of IE[k] & (OVF[k] | UDF[k]), driven from register state (no extra pipeline stage).
- Reads:
  - On i_rden, o_rdata is loaded with the selected register.
  - o_rdata holds its value while i_rden is low.
  - Same-cycle read and write: the read returns the pre-write value.

## Timing
- Reset: all registers and o_rdata = 0; o_en, o_dir, o_cs, o_load, o_irq = 0; CSP = 0.
- Write at cycle T: o_en, o_dir, o_cs (immediate path) and o_load update at T+1. o_load drops at T+2.
- Event pulse at T: flag visible on read at T+1. o_irq asserts at T+1 if IE is set.
- i_upd at T with CSP set: new o_cs at T+1.
- Read latency: o_rdata valid at T+1 for i_rden at T.
- Reset asserted mid-operation: takes effect at the next edge. It discards pending shadow and flags, and suppresses any o_load that would have fired.

## Test plan
- Reset, then read control and status for all channels -> every read 0x00; o_irq = 0; o_cs = 0.
- Write ch1 control 0x85 (EN=1, CS=1, LOAD) -> o_en[1]=1 and o_cs ch1=1 next cycle; o_load[1] high for exactly 1 cycle; readback 0x05.
- ch1 running, write 0x0D (CS=3) -> o_cs ch1 stays 1 and status CSP=1. Pulse i_upd[1] -> o_cs ch1=3 next cycle, CSP=0. Repeat with the write and i_upd in the same cycle -> old shadow applied, CSP remains 1.
- Set IE on ch2, pulse i_ovf[2] -> status reads 0x01 and o_irq=1. Write status 0x01 in the same cycle as another i_ovf[2] -> flag stays 1. Write 0x01 alone -> flag 0, o_irq 0.
- i_udf[0] with IE[0]=0 -> UDF=1, o_irq=0. Then set IE[0] -> o_irq=1 the next cycle.
- Write and read with i_addr=N_CH -> no state change and read 0x00. Assert i_rst while CSP=1 and a LOAD write is in flight -> no o_load pulse, all state 0.

Source files
------------

// File: rtl/tmr_ctrl_regs.sv
// tmr_ctrl_regs: per-channel control/status register bank for the APB timer.
// Each channel has a control register (EN, DIR, CS, IE, LOAD strobe), a sticky
// W1C status register (OVF, UDF, CSP) and a clock-select shadow that is
// transferred to the active value on the counter boundary while running.
module tmr_ctrl_regs #(
  parameter int N_CH = 4,
  parameter int CS_W = 2,
  parameter int AW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   i_clk_sys,
  input  logic                   i_rst,
  input  logic                   i_wren,
  input  logic                   i_rden,
  input  logic [AW-1:0]          i_addr,
  input  logic                   i_sel,
  input  logic [7:0]             i_wdata,
  output logic [7:0]             o_rdata,
  input  logic [N_CH-1:0]        i_ovf,
  input  logic [N_CH-1:0]        i_udf,
  input  logic [N_CH-1:0]        i_upd,
  output logic [N_CH-1:0]        o_en,
  output logic [N_CH-1:0]        o_dir,
  output logic [N_CH*CS_W-1:0]   o_cs,
  output logic [N_CH-1:0]        o_load,
  output logic                   o_irq
);

  logic [N_CH-1:0] en_q, dir_q, ie_q, load_q, csp_q, ovf_q, udf_q;
  logic [CS_W-1:0] cs_q [N_CH];
  logic [CS_W-1:0] sh_q [N_CH];

  logic            addr_ok;
  logic [N_CH-1:0] wr_ctrl, wr_stat;
  logic [CS_W-1:0] wr_cs;
  logic [7:0]      rd_val;
  logic            unused_wdata;

  assign addr_ok      = 32'(i_addr) < N_CH;
  assign wr_cs        = i_wdata[2 +: CS_W];
  assign unused_wdata = ^i_wdata;

  // Per-channel write strobes; out-of-range addresses select nothing.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ctrl = '0;
    wr_stat = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (i_wren && addr_ok && (i_addr == AW'(k))) begin
        wr_ctrl[k] = ~i_sel;
        wr_stat[k] = i_sel;
      end
    end
  end

  // Read mux: the selected register image, zero for unimplemented bits/channels.
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (addr_ok && (i_addr == AW'(k))) begin
        if (i_sel) begin
          rd_val[0] = ovf_q[k];
          rd_val[1] = udf_q[k];
          rd_val[2] = csp_q[k];
        end else begin
          rd_val[0]          = en_q[k];
          rd_val[1]          = dir_q[k];
          rd_val[2 +: CS_W]  = cs_q[k];
          rd_val[6]          = ie_q[k];
        end
      end
    end
  end

  // Channel state: control fields, clock-select shadowing, load strobe, sticky flags.
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      en_q   <= '0;
      dir_q  <= '0;
      ie_q   <= '0;
      load_q <= '0;
      csp_q  <= '0;
      ovf_q  <= '0;
      udf_q  <= '0;
      // NOTE: the shadow array is tiny flop storage, so it is reset along with
      // everything else; a pending value must never survive reset.
      for (int k = 0; k < N_CH; k++) begin
        cs_q[k] <= '0;
        sh_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        load_q[k] <= wr_ctrl[k] & i_wdata[7];
        // A set event in the same cycle as a W1C write wins.
        ovf_q[k]  <= i_ovf[k] | (ovf_q[k] & ~(wr_stat[k] & i_wdata[0]));
        udf_q[k]  <= i_udf[k] | (udf_q[k] & ~(wr_stat[k] & i_wdata[1]));
        if (wr_ctrl[k]) begin
          en_q[k]  <= i_wdata[0];
          dir_q[k] <= i_wdata[1];
          ie_q[k]  <= i_wdata[6];
          if (en_q[k] && i_wdata[0]) begin
            // Running and staying on: defer CS to the next boundary. A boundary
            // this same cycle still applies the previous shadow.
            sh_q[k]  <= wr_cs;
            csp_q[k] <= 1'b1;
            if (csp_q[k] && i_upd[k]) cs_q[k] <= sh_q[k];
          end else begin
            cs_q[k]  <= wr_cs;
            csp_q[k] <= 1'b0;
          end
        end else if (csp_q[k] && i_upd[k]) begin
          cs_q[k]  <= sh_q[k];
          csp_q[k] <= 1'b0;
        end
      end
    end
  end

  // Registered read data, held while no read is requested.
  always_ff @(posedge i_clk_sys) begin
    if (i_rst)       o_rdata <= '0;
    else if (i_rden) o_rdata <= rd_val;
  end

  // Pack the active clock selects onto the flat output bus.
  always_comb begin
    o_cs = '0;
    for (int k = 0; k < N_CH; k++) o_cs[k*CS_W +: CS_W] = cs_q[k];
  end

  assign o_en   = en_q;
  assign o_dir  = dir_q;
  assign o_load = load_q;
  assign o_irq  = |(ie_q & (ovf_q | udf_q));

endmodule
